// File: rtl/mmu_pkg.sv
// -----------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the fixed-mapping MIPS32 segment translator:
// segment base addresses, the physical mask applied to unmapped kernel
// segments, the segment identifier enum and a helper that classifies a
// virtual address into its segment.
// -----------------------------------------------------------------------------
package mmu_pkg;

  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;
  localparam logic [31:0] PHYS_MASK  = 32'h1FFF_FFFF;

  typedef enum logic [1:0] {
    KUSEG  = 2'd0,
    KSEG0  = 2'd1,
    KSEG1  = 2'd2,
    KSEG23 = 2'd3
  } seg_e;

  // Classify a virtual address by its top three bits.
  function automatic seg_e seg_of(input logic [31:0] va);
    seg_e s;
    case (va[31:29])
      3'b100:  s = KSEG0;
      3'b101:  s = KSEG1;
      3'b110:  s = KSEG23;
      3'b111:  s = KSEG23;
      default: s = KUSEG;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmu_seg_decode.sv
// -----------------------------------------------------------------------------
// mmu_seg_decode
// Single-channel combinational segment decoder.
// Ports:
//   i_va          virtual address
//   i_en          access valid this cycle (qualifies the illegal flag only)
//   i_user_mode   1 = user mode
//   i_k0_uncached 1 = kseg0 treated as uncached
//   o_pa          direct physical address (meaningful when o_tlb_map = 0)
//   o_uncached    access is uncached
//   o_tlb_map     address lies in a TLB-mapped segment
//   o_illegal     user-mode access to a kernel segment
// -----------------------------------------------------------------------------
module mmu_seg_decode
  import mmu_pkg::*;
(
  input  logic [31:0] i_va,
  input  logic        i_en,
  input  logic        i_user_mode,
  input  logic        i_k0_uncached,
  output logic [31:0] o_pa,
  output logic        o_uncached,
  output logic        o_tlb_map,
  output logic        o_illegal
);

  seg_e w_seg;

  assign w_seg = seg_of(i_va);

  // Segment decode: pa/tlb_map/uncached depend only on the address and the
  // kseg0 cache attribute, never on en or user_mode.
  always_comb begin
    o_pa       = i_va;
    o_uncached = 1'b0;
    o_tlb_map  = 1'b1;
    case (w_seg)
      KUSEG: begin
        o_pa       = i_va;
        o_uncached = 1'b0;
        o_tlb_map  = 1'b1;
      end
      KSEG0: begin
        o_pa       = i_va & PHYS_MASK;
        o_uncached = i_k0_uncached;
        o_tlb_map  = 1'b0;
      end
      KSEG1: begin
        o_pa       = i_va & PHYS_MASK;
        o_uncached = 1'b1;
        o_tlb_map  = 1'b0;
      end
      KSEG23: begin
        o_pa       = i_va;
        o_uncached = 1'b0;
        o_tlb_map  = 1'b1;
      end
      default: begin
        o_pa       = i_va;
        o_uncached = 1'b0;
        o_tlb_map  = 1'b1;
      end
    endcase
  end

  // Every segment with va[31]=1 is kernel-only.
  assign o_illegal = i_en & i_user_mode & i_va[31];

endmodule

// File: rtl/mmu.sv
// -----------------------------------------------------------------------------
// mmu
// Fixed-mapping address translator for the instruction and data ports.
// Two independent, purely combinational channels; clk/rst exist only for
// interface uniformity inside cp0 and have no functional effect.
// Ports:
//   clk, rst                 unused clock / synchronous active-high reset
//   iaddr_i, daddr_i         instruction / data virtual addresses
//   inst_en, data_en         access valid strobes
//   user_mode                1 = user mode
//   cp0_kseg0_uncached       1 = kseg0 uncached
//   iaddr_o, daddr_o         direct physical addresses
//   inst_uncached, data_uncached
//   inst_tlb_map, data_tlb_map   address needs TLB translation
//   inst_illegal, data_illegal   privilege violation
// -----------------------------------------------------------------------------
module mmu
  import mmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr_i,
  input  logic [31:0] daddr_i,
  input  logic        inst_en,
  input  logic        data_en,
  input  logic        user_mode,
  input  logic        cp0_kseg0_uncached,
  output logic [31:0] iaddr_o,
  output logic [31:0] daddr_o,
  output logic        inst_uncached,
  output logic        data_uncached,
  output logic        inst_tlb_map,
  output logic        data_tlb_map,
  output logic        inst_illegal,
  output logic        data_illegal
);

  // clk and rst are deliberately not used by any logic.
  logic w_unused;
  assign w_unused = clk ^ rst;

  mmu_seg_decode u_inst_dec (
    .i_va          (iaddr_i),
    .i_en          (inst_en),
    .i_user_mode   (user_mode),
    .i_k0_uncached (cp0_kseg0_uncached),
    .o_pa          (iaddr_o),
    .o_uncached    (inst_uncached),
    .o_tlb_map     (inst_tlb_map),
    .o_illegal     (inst_illegal)
  );

  mmu_seg_decode u_data_dec (
    .i_va          (daddr_i),
    .i_en          (data_en),
    .i_user_mode   (user_mode),
    .i_k0_uncached (cp0_kseg0_uncached),
    .o_pa          (daddr_o),
    .o_uncached    (data_uncached),
    .o_tlb_map     (data_tlb_map),
    .o_illegal     (data_illegal)
  );

endmodule

// File: tb/tb_mmu.sv
// -----------------------------------------------------------------------------
// tb_mmu
// Self-checking bench for mmu: directed test-plan steps, address boundaries
// and randomized accesses compared against an address-range reference model.
// -----------------------------------------------------------------------------
module tb_mmu;

  logic        clk;
  logic        rst;
  logic [31:0] iaddr_i;
  logic [31:0] daddr_i;
  logic        inst_en;
  logic        data_en;
  logic        user_mode;
  logic        cp0_kseg0_uncached;
  logic [31:0] iaddr_o;
  logic [31:0] daddr_o;
  logic        inst_uncached;
  logic        data_uncached;
  logic        inst_tlb_map;
  logic        data_tlb_map;
  logic        inst_illegal;
  logic        data_illegal;

  int errors;
  int checks;

  mmu dut (
    .clk                (clk),
    .rst                (rst),
    .iaddr_i            (iaddr_i),
    .daddr_i            (daddr_i),
    .inst_en            (inst_en),
    .data_en            (data_en),
    .user_mode          (user_mode),
    .cp0_kseg0_uncached (cp0_kseg0_uncached),
    .iaddr_o            (iaddr_o),
    .daddr_o            (daddr_o),
    .inst_uncached      (inst_uncached),
    .data_uncached      (data_uncached),
    .inst_tlb_map       (inst_tlb_map),
    .data_tlb_map       (data_tlb_map),
    .inst_illegal       (inst_illegal),
    .data_illegal       (data_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model expressed as address ranges and offsets.
  task automatic ref_decode(input logic [31:0] va, input logic en, input logic um,
                            input logic k0u, output logic [31:0] pa,
                            output logic unc, output logic map, output logic ill);
    if (va < 32'h8000_0000) begin
      pa = va; unc = 1'b0; map = 1'b1;
    end else if (va < 32'hA000_0000) begin
      pa = va - 32'h8000_0000; unc = k0u; map = 1'b0;
    end else if (va < 32'hC000_0000) begin
      pa = va - 32'hA000_0000; unc = 1'b1; map = 1'b0;
    end else begin
      pa = va; unc = 1'b0; map = 1'b1;
    end
    ill = en && um && (va >= 32'h8000_0000);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive all inputs away from the rising edge, let them settle, check all outputs.
  task automatic step(input logic [31:0] ia, input logic [31:0] da, input logic ie,
                      input logic de, input logic um, input logic k0u, input logic r);
    logic [31:0] epa;
    logic eunc, emap, eill;
    @(negedge clk);
    iaddr_i = ia; daddr_i = da; inst_en = ie; data_en = de;
    user_mode = um; cp0_kseg0_uncached = k0u; rst = r;
    #1;
    ref_decode(ia, ie, um, k0u, epa, eunc, emap, eill);
    check($sformatf("iaddr_o va=%h", ia), iaddr_o, epa);
    check($sformatf("inst_uncached va=%h", ia), {31'd0, inst_uncached}, {31'd0, eunc});
    check($sformatf("inst_tlb_map va=%h", ia), {31'd0, inst_tlb_map}, {31'd0, emap});
    check($sformatf("inst_illegal va=%h", ia), {31'd0, inst_illegal}, {31'd0, eill});
    ref_decode(da, de, um, k0u, epa, eunc, emap, eill);
    check($sformatf("daddr_o va=%h", da), daddr_o, epa);
    check($sformatf("data_uncached va=%h", da), {31'd0, data_uncached}, {31'd0, eunc});
    check($sformatf("data_tlb_map va=%h", da), {31'd0, data_tlb_map}, {31'd0, emap});
    check($sformatf("data_illegal va=%h", da), {31'd0, data_illegal}, {31'd0, eill});
  endtask

  initial begin
    logic [31:0] bnd [0:6];
    errors = 0;
    checks = 0;
    rst = 1'b1;
    iaddr_i = 32'd0; daddr_i = 32'd0; inst_en = 1'b0; data_en = 1'b0;
    user_mode = 1'b0; cp0_kseg0_uncached = 1'b0;
    bnd[0] = 32'h7FFF_FFFF; bnd[1] = 32'h8000_0000; bnd[2] = 32'h9FFF_FFFF;
    bnd[3] = 32'hA000_0000; bnd[4] = 32'hBFFF_FFFF; bnd[5] = 32'hC000_0000;
    bnd[6] = 32'hFFFF_FFFF;

    // Outputs during reset follow inputs.
    step(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'hA000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Explicit test-plan values, independent of the model.
    step(32'hBFC0_0000, 32'h8000_1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("plan kseg0 daddr_o", daddr_o, 32'h0000_1234);
    check("plan kseg1 iaddr_o", iaddr_o, 32'h1FC0_0000);
    check("plan kseg1 inst_uncached", {31'd0, inst_uncached}, 32'd1);
    check("plan kseg0 data_uncached", {31'd0, data_uncached}, 32'd0);
    step(32'hBFC0_0000, 32'h8000_1234, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("plan k0 override uncached", {31'd0, data_uncached}, 32'd1);
    check("plan k0 override daddr_o", daddr_o, 32'h0000_1234);
    step(32'h0000_0000, 32'h0040_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("plan kuseg map", {31'd0, data_tlb_map}, 32'd1);
    check("plan kuseg daddr_o", daddr_o, 32'h0040_0000);
    step(32'h0000_0000, 32'hC000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("plan kseg2 map", {31'd0, data_tlb_map}, 32'd1);
    step(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("plan user illegal", {31'd0, data_illegal}, 32'd1);
    step(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("plan user en=0 legal", {31'd0, data_illegal}, 32'd0);
    step(32'h0000_0000, 32'h7FFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("plan user kuseg legal", {31'd0, data_illegal}, 32'd0);
    check("plan user kuseg map", {31'd0, data_tlb_map}, 32'd1);

    // Independence across an rst toggle.
    step(32'hA000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(32'hA000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Boundary addresses on both channels under every mode combination.
    for (int i = 0; i < 7; i++) begin
      for (int m = 0; m < 8; m++) begin
        step(bnd[i], bnd[6 - i], m[0], ~m[0], m[1], m[2], 1'b0);
      end
    end

    // Randomized accesses, occasionally with rst asserted.
    for (int n = 0; n < 300; n++) begin
      step($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmu.md
Name: mmu

Overview:
- Fixed-mapping address translator (MIPS32 segment decode) for the CPU's instruction and data ports.
- Sits inside cp0, which muxes between this block's direct physical address and the TLB lookup result using the *_tlb_map flags it produces.
- Two identical, independent channels: instruction and data.
- Purely combinational translation; clk/rst are present for interface uniformity.

Parameters:
- none

Ports:
- clk  input  1  system clock. No registered state.
- rst  input  1  reset, synchronous, active-high. No state to clear.
- iaddr_i  input  32  instruction virtual address.
- daddr_i  input  32  data virtual address.
- inst_en  input  1  instruction access valid this cycle.
- data_en  input  1  data access valid this cycle.
- user_mode  input  1  1 = user mode (kernel segments forbidden).
- cp0_kseg0_uncached  input  1  1 = treat kseg0 as uncached (Config.K0 uncached).
- iaddr_o  output  32  instruction direct (unmapped) physical address.
- daddr_o  output  32  data direct (unmapped) physical address.
- inst_uncached  output  1  instruction access is uncached.
- data_uncached  output  1  data access is uncached.
- inst_tlb_map  output  1  instruction address lies in a TLB-mapped segment.
- data_tlb_map  output  1  data address lies in a TLB-mapped segment.
- inst_illegal  output  1  instruction address-error (privilege violation).
- data_illegal  output  1  data address-error (privilege violation).

Behaviour:
- Both channels apply the same function; va[31:29] selects the segment.

Per-channel decode, for va = *addr_i:
- kuseg, va[31]=0 (0x0000_0000..0x7FFF_FFFF): tlb_map=1, uncached=0, pa_o=va.
- kseg0, va[31:29]=100: tlb_map=0, pa_o={3'b000,va[28:0]}, uncached=cp0_kseg0_uncached.
- kseg1, va[31:29]=101: tlb_map=0, pa_o={3'b000,va[28:0]}, uncached=1.
- kseg2/kseg3, va[31:30]=11: tlb_map=1, uncached=0, pa_o=va.

Illegal access:
- illegal = en & user_mode & va[31].
- When en=0, illegal=0 regardless of address or mode.
- pa_o, tlb_map and uncached are computed regardless of en and user_mode. They are pure address decode; illegal does not mask them.

Timing and reset:
- All outputs are combinational, with zero-cycle latency from inputs. No handshake.
- rst has no functional effect: outputs depend only on current inputs, both during and after reset.
- The two channels never interact. Simultaneous inst and data accesses to any segments are decoded independently.

Boundary addresses:
- 0x7FFF_FFFF: mapped.
- 0x8000_0000: kseg0, pa=0x0000_0000.
- 0x9FFF_FFFF: pa=0x1FFF_FFFF.
- 0xA000_0000: kseg1, pa=0.
- 0xBFFF_FFFF: pa=0x1FFF_FFFF.
- 0xC000_0000: mapped.
- 0xFFFF_FFFF: mapped.

Decomposition:
- Shared package: segment base constants KSEG0_BASE=32'h8000_0000, KSEG1_BASE=32'h A000_0000, KSEG2_BASE=32'hC000_0000.
- Shared package: PHYS_MASK=32'h1FFF_FFFF.
- Shared package: an enum for segment id {KUSEG, KSEG0, KSEG1, KSEG23}.
- One sub-module, mmu_seg_decode: a single-channel decoder with inputs va, en, user_mode, k0_uncached and outputs pa, uncached, tlb_map, illegal. It is instantiated twice (inst, data).

Test Plan:
- Kernel kseg0 access: daddr_i=0x8000_1234, data_en=1, user_mode=0, cp0_kseg0_uncached=0 -> daddr_o=0x0000_1234, data_uncached=0, data_tlb_map=0, data_illegal=0.
- kseg0 uncached override: same address with cp0_kseg0_uncached=1 -> data_uncached=1; daddr_o unchanged.
- kseg1 access: iaddr_i=0xBFC0_0000, inst_en=1 -> iaddr_o=0x1FC0_0000, inst_uncached=1, inst_tlb_map=0, inst_illegal=0.
- Mapped segments: daddr_i=0x0040_0000 -> data_tlb_map=1, daddr_o=0x0040_0000, data_uncached=0. daddr_i=0xC000_0000 -> data_tlb_map=1.
- User-mode privilege: user_mode=1, data_en=1, daddr_i=0x8000_0000 -> data_illegal=1. Same with data_en=0 -> data_illegal=0. user_mode=1, daddr_i=0x7FFF_FFFC -> data_illegal=0, data_tlb_map=1.
- Independence and reset: iaddr_i=0xA000_0000 and daddr_i=0x8000_0000 simultaneously, rst toggled -> each channel decodes correctly and outputs are unaffected by rst.
